cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
// Direct-mapped, write-through, write-allocate cache control FSM sitting directly upstream of the data-line array.
// Accepts CPU load/store requests, checks tag/valid state and fills lines from memory on a miss.
// Drives the data-line array's write/select/size controls and returns loaded data to the CPU.
// PARAMETERS
// XLEN            32  data/address width
// NUM_SETS        4   number of lines; SET_SIZE = $clog2(NUM_SETS)
// WORDS_PER_LINE  8   words per line; WORD_SELECT_SIZE = $clog2(WORDS_PER_LINE)
// BYTE_SELECT_SIZE 2  byte offset width; TAG_SIZE = XLEN-SET_SIZE-WORD_SELECT_SIZE-BYTE_SELECT_SIZE
// PORTS
// clk            in   1    clock
// rst_n          in   1    asynchronous, active-low reset
// req_valid      in   1    CPU request valid
// req_ready      out  1    1 only in IDLE; transfer = req_valid & req_ready
// req_op         in   enum memory_operation_e (LOAD/STORE)
// req_size       in   enum memory_operation_size_e (BYTE/HALF/WORD)
// req_addr       in   XLEN byte address
// req_wdata      in   XLEN store data, right-aligned
// resp_valid     out  1    one-cycle pulse, request complete
// resp_rdata     out  XLEN load data, zero-extended; 0 for stores
// resp_error     out  1    misaligned request, valid with resp_valid
// flush          in   1    invalidate all lines; honoured only in IDLE with no transfer
// mem_req        out  1    memory request, held until mem_ready
// mem_we         out  1    1 = write-through, 0 = fill read
// mem_addr       out  XLEN word-aligned for fills, original address for writes
// mem_size       out  enum size: WORD for fills, req_size for writes
// mem_wdata      out  XLEN store data
// mem_ready      in   1    completes mem_req; read data valid same cycle
// mem_rdata      in   XLEN fill word
// dl_perform_write out 1   data-line write strobe
// dl_set         out  SET_SIZE
// dl_op_size     out  enum
// dl_word_select out  WORD_SELECT_SIZE
// dl_byte_select out  BYTE_SELECT_SIZE
// dl_word_to_store out XLEN
// dl_fetched_word in  XLEN combinational read from the data-line array
// BEHAVIOUR
// - Reset: state IDLE; all valid bits 0; every output 0; req_ready 1. Tags are not reset.
//   Reset mid-fill aborts: line stays invalid and mem_req drops immediately.
// - Address split: [byte | word | set | tag], LSB first. The request is registered on transfer.
// - IDLE -> LOOKUP on transfer. flush in IDLE clears all valid bits in one cycle. flush and req_valid in the same cycle: the request wins, flush is ignored.
// - LOOKUP, misaligned (HALF with addr[0]=1; WORD with addr[1:0]!=0): resp_valid=1, resp_error=1, no mem or data-line write, -> IDLE.
// - LOOKUP, load hit: dl_* selects the request; resp_rdata = dl_fetched_word; resp_valid this cycle (load-hit latency 1); -> IDLE.
// - LOOKUP, store hit: dl_perform_write=1 with req size/offset/data this cycle; -> WRITE_MEM.
// - LOOKUP, miss (either op): valid[set]=0, tag[set]=req tag, cnt=0; -> FILL.
// - FILL: mem_req=1, mem_we=0, mem_addr={tag,set,cnt,2'b00}.
//   On mem_ready: dl_perform_write=1, dl_op_size=WORD, dl_word_select=cnt, word_to_store=mem_rdata, cnt++.
//   When cnt==WORDS_PER_LINE-1 and mem_ready: valid[set]=1 and -> LOOKUP, which then replays as a hit.
// - WRITE_MEM: mem_req=1, mem_we=1. On mem_ready: resp_valid=1, -> IDLE.
// - mem_req, mem_addr and mem_wdata stay stable while mem_req=1 and mem_ready=0.
// - At most one outstanding CPU and memory transaction at any time.
// STRUCTURE
// - torrence_types: add memory_operation_e {LOAD, STORE} and cache_state_e {IDLE, LOOKUP, FILL, WRITE_MEM}; memory_operation_size_e is reused unchanged.
// - Sub-module cache_tag_array: per-set tag registers plus async-reset valid bits; ports for lookup, set_tag, set_valid, clear_valid and flush.
// TESTING
// - Cold load WORD 0x0000_0040, mem returns 0x100+i for word i:
//   -> 8 reads to 0x40..0x5C, then resp_rdata=0x100; resp_valid 10 cycles after transfer with zero-wait memory.
// - Load WORD 0x44 after the fill -> resp_valid the cycle after transfer, rdata=0x101, no mem_req.
// - Store BYTE 0xAB to 0x45 (hit) -> data-line write with byte_select=1; mem write to addr 0x45 size BYTE.
//   A subsequent load WORD 0x44 returns 0x0000_AB01.
// - Load HALF 0x43 -> resp_error=1, no mem_req, no state change.
// - Load 0x0000_0240 after the first fill (same set, new tag) -> miss, refill; flush then reload 0x40 -> miss.
// - Assert rst_n mid-FILL at cnt=3 -> mem_req=0 immediately; next load to 0x40 refetches all 8 words.

Source files
------------

// File: rtl/cache_controller_pkg.sv
// Shared types, geometry and address helpers for the direct-mapped cache controller.
// Pure declarations, no latency of its own.
// No flow control here; consumers own the handshakes.
package cache_controller_pkg;

  localparam int XLEN             = 32;
  localparam int NUM_SETS         = 4;
  localparam int WORDS_PER_LINE   = 8;
  localparam int SET_SIZE         = $clog2(NUM_SETS);
  localparam int WORD_SELECT_SIZE = $clog2(WORDS_PER_LINE);
  localparam int BYTE_SELECT_SIZE = 2;
  localparam int TAG_SIZE         = XLEN - SET_SIZE - WORD_SELECT_SIZE - BYTE_SELECT_SIZE;

  typedef enum logic {LOAD = 1'b0, STORE = 1'b1} memory_operation_e;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} memory_operation_size_e;
  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, FILL = 2'd2, WRITE_MEM = 2'd3} cache_state_e;

  // Byte address split, MSB first: tag | set | word | byte offset.
  typedef struct packed {
    logic [TAG_SIZE-1:0]         tag;
    logic [SET_SIZE-1:0]         set;
    logic [WORD_SELECT_SIZE-1:0] word;
    logic [BYTE_SELECT_SIZE-1:0] byte_off;
  } addr_t;

  function automatic logic is_misaligned(memory_operation_size_e size,
                                         logic [BYTE_SELECT_SIZE-1:0] off);
    case (size)
      HALF:    return off[0];
      WORD:    return off != '0;
      default: return 1'b0;
    endcase
  endfunction

  // Word-aligned address of word w inside the line that holds a.
  function automatic logic [XLEN-1:0] line_word_addr(addr_t a, logic [WORD_SELECT_SIZE-1:0] w);
    return {a.tag, a.set, w, {BYTE_SELECT_SIZE{1'b0}}};
  endfunction

  // The data-line array returns the selected sub-word right-aligned; clear the unused upper bits.
  function automatic logic [XLEN-1:0] zero_extend(logic [XLEN-1:0] w, memory_operation_size_e size);
    case (size)
      BYTE:    return {{(XLEN-8){1'b0}}, w[7:0]};
      HALF:    return {{(XLEN-16){1'b0}}, w[15:0]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Bundles the CPU request/response, memory and data-line array signals of the cache controller.
// Wires only, no latency.
// Handshakes: req_valid/req_ready for CPU, mem_req held until mem_ready for memory.
interface cache_controller_if;
  import cache_controller_pkg::*;

  // CPU side
  logic                        req_valid;
  logic                        req_ready;
  memory_operation_e           req_op;
  memory_operation_size_e      req_size;
  logic [XLEN-1:0]             req_addr;
  logic [XLEN-1:0]             req_wdata;
  logic                        resp_valid;
  logic [XLEN-1:0]             resp_rdata;
  logic                        resp_error;
  logic                        flush;
  // Memory side
  logic                        mem_req;
  logic                        mem_we;
  logic [XLEN-1:0]             mem_addr;
  memory_operation_size_e      mem_size;
  logic [XLEN-1:0]             mem_wdata;
  logic                        mem_ready;
  logic [XLEN-1:0]             mem_rdata;
  // Data-line array side
  logic                        dl_perform_write;
  logic [SET_SIZE-1:0]         dl_set;
  memory_operation_size_e      dl_op_size;
  logic [WORD_SELECT_SIZE-1:0] dl_word_select;
  logic [BYTE_SELECT_SIZE-1:0] dl_byte_select;
  logic [XLEN-1:0]             dl_word_to_store;
  logic [XLEN-1:0]             dl_fetched_word;

  // Environment view: CPU, memory and data-line array together.
  modport master (
    output req_valid, req_op, req_size, req_addr, req_wdata, flush,
           mem_ready, mem_rdata, dl_fetched_word,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_req, mem_we, mem_addr, mem_size, mem_wdata,
           dl_perform_write, dl_set, dl_op_size, dl_word_select, dl_byte_select, dl_word_to_store
  );

  // Controller view.
  modport slave (
    input  req_valid, req_op, req_size, req_addr, req_wdata, flush,
           mem_ready, mem_rdata, dl_fetched_word,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_req, mem_we, mem_addr, mem_size, mem_wdata,
           dl_perform_write, dl_set, dl_op_size, dl_word_select, dl_byte_select, dl_word_to_store
  );

endinterface

// File: rtl/cache_controller_tag_array.sv
// Per-set tag registers and valid bits for the direct-mapped cache.
// Lookup is combinational; updates land on the next clock edge.
// No backpressure; the controller issues at most one update per cycle.
module cache_tag_array
  import cache_controller_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SET_SIZE-1:0] i_lookup_set,
  output logic [TAG_SIZE-1:0] o_lookup_tag,
  output logic                o_lookup_valid,
  input  logic                i_set_tag,
  input  logic                i_set_valid,
  input  logic                i_clear_valid,
  input  logic                i_flush,
  input  logic [SET_SIZE-1:0] i_wr_set,
  input  logic [TAG_SIZE-1:0] i_wr_tag
);

  logic [TAG_SIZE-1:0] r_tag [NUM_SETS];
  logic [NUM_SETS-1:0] r_valid;

  // Tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (i_set_tag) r_tag[i_wr_set] <= i_wr_tag;
  end

  // Valid bits: flush clears everything, otherwise per-set clear on miss / set on fill completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_clear_valid) begin
      r_valid[i_wr_set] <= 1'b0;
    end else if (i_set_valid) begin
      r_valid[i_wr_set] <= 1'b1;
    end
  end

  assign o_lookup_tag   = r_tag[i_lookup_set];
  assign o_lookup_valid = r_valid[i_lookup_set];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-through/write-allocate cache control FSM in front of the data-line array.
// Load hit responds 1 cycle after transfer; a miss fills 8 words then replays as a hit.
// req_ready only in IDLE; mem_req and its address/data are held stable until mem_ready.
module cache_controller
  import cache_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  cache_controller_if.slave  bus
);

  cache_state_e                r_state;
  memory_operation_e           r_op;
  memory_operation_size_e      r_size;
  addr_t                       r_addr;
  logic [XLEN-1:0]             r_wdata;
  logic [WORD_SELECT_SIZE-1:0] r_cnt;
  logic                        r_mem_req;
  logic                        r_mem_we;
  logic [XLEN-1:0]             r_mem_addr;
  memory_operation_size_e      r_mem_size;
  logic [XLEN-1:0]             r_mem_wdata;

  logic [TAG_SIZE-1:0]         w_lookup_tag;
  logic                        w_lookup_valid;
  logic                        w_in_lookup;
  logic                        w_in_fill;
  logic                        w_misaligned;
  logic                        w_hit;
  logic                        w_load_hit;
  logic                        w_store_hit;
  logic                        w_miss;
  logic                        w_fill_beat;
  logic                        w_fill_last;
  logic                        w_flush;
  logic [WORD_SELECT_SIZE-1:0] w_next_cnt;

  assign w_in_lookup  = (r_state == LOOKUP);
  assign w_in_fill    = (r_state == FILL);
  assign w_misaligned = is_misaligned(r_size, r_addr.byte_off);
  assign w_hit        = w_lookup_valid && (w_lookup_tag == r_addr.tag);
  assign w_load_hit   = w_in_lookup && !w_misaligned && w_hit && (r_op == LOAD);
  assign w_store_hit  = w_in_lookup && !w_misaligned && w_hit && (r_op == STORE);
  assign w_miss       = w_in_lookup && !w_misaligned && !w_hit;
  assign w_fill_beat  = w_in_fill && bus.mem_ready;
  assign w_fill_last  = w_fill_beat && (r_cnt == WORD_SELECT_SIZE'(WORDS_PER_LINE - 1));
  assign w_next_cnt   = r_cnt + 1'b1;
  // A request arriving together with flush wins; the flush is dropped.
  assign w_flush      = (r_state == IDLE) && bus.flush && !bus.req_valid;

  cache_tag_array u_tags (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_lookup_set   (r_addr.set),
    .o_lookup_tag   (w_lookup_tag),
    .o_lookup_valid (w_lookup_valid),
    .i_set_tag      (w_miss),
    .i_set_valid    (w_fill_last),
    .i_clear_valid  (w_miss),
    .i_flush        (w_flush),
    .i_wr_set       (r_addr.set),
    .i_wr_tag       (r_addr.tag)
  );

  // Main FSM: captures the request, sequences line fills and write-through, registers memory outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= LOAD;
      r_size      <= BYTE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_size  <= BYTE;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_op    <= bus.req_op;
            r_size  <= bus.req_size;
            r_addr  <= addr_t'(bus.req_addr);
            r_wdata <= bus.req_wdata;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_misaligned) begin
            r_state <= IDLE;
          end else if (w_hit) begin
            if (r_op == STORE) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_addr;
              r_mem_size  <= r_size;
              r_mem_wdata <= r_wdata;
              r_state     <= WRITE_MEM;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt       <= '0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= line_word_addr(r_addr, '0);
            r_mem_size  <= WORD;
            r_mem_wdata <= r_wdata;
            r_state     <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_ready) begin
            r_cnt      <= w_next_cnt;
            r_mem_addr <= line_word_addr(r_addr, w_next_cnt);
            if (r_cnt == WORD_SELECT_SIZE'(WORDS_PER_LINE - 1)) begin
              // Line complete: go back to LOOKUP so the request replays as a hit.
              r_mem_req <= 1'b0;
              r_state   <= LOOKUP;
            end
          end
        end
        WRITE_MEM: begin
          if (bus.mem_ready) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (w_in_lookup && w_misaligned) || w_load_hit
                        || ((r_state == WRITE_MEM) && bus.mem_ready);
  assign bus.resp_error = w_in_lookup && w_misaligned;
  assign bus.resp_rdata = w_load_hit ? zero_extend(bus.dl_fetched_word, r_size) : '0;

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_size  = r_mem_size;
  assign bus.mem_wdata = r_mem_wdata;

  // During a fill the data-line port writes whole words at the fill counter; otherwise it follows the request.
  assign bus.dl_perform_write = w_fill_beat || w_store_hit;
  assign bus.dl_set           = r_addr.set;
  assign bus.dl_op_size       = w_in_fill ? WORD : r_size;
  assign bus.dl_word_select   = w_in_fill ? r_cnt : r_addr.word;
  assign bus.dl_byte_select   = w_in_fill ? '0 : r_addr.byte_off;
  assign bus.dl_word_to_store = w_in_fill ? bus.mem_rdata : r_wdata;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a functional memory and a data-line array model.
// Memory answers in the request cycle unless stalling is enabled.
// Stall mode exercises mem_req hold-and-stable behaviour.
module tb_cache_controller;
  import cache_controller_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_controller_if bus();
  cache_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_compared = 0;
  int n_mismatch = 0;

  // Memory model: word at address a holds 0x100 + word index + (tag << 12).
  logic       stall_en = 1'b0;
  logic [7:0] tick = '0;
  always @(posedge clk) tick <= tick + 8'd1;
  assign bus.mem_ready = bus.mem_req & (!stall_en | (tick[1:0] == 2'b11));
  assign bus.mem_rdata = 32'h100 + {29'b0, bus.mem_addr[4:2]} + ({7'b0, bus.mem_addr[31:7]} << 12);

  // Data-line array model: sized writes, right-aligned sized reads.
  logic [31:0] dl_arr [4][8];
  logic [31:0] dl_raw;
  assign dl_raw = dl_arr[bus.dl_set][bus.dl_word_select] >> {bus.dl_byte_select, 3'b000};
  assign bus.dl_fetched_word = (bus.dl_op_size == BYTE) ? {24'b0, dl_raw[7:0]} :
                               (bus.dl_op_size == HALF) ? {16'b0, dl_raw[15:0]} : dl_raw;
  always @(posedge clk) begin
    if (bus.dl_perform_write === 1'b1) begin
      case (bus.dl_op_size)
        WORD:    dl_arr[bus.dl_set][bus.dl_word_select] <= bus.dl_word_to_store;
        HALF:    dl_arr[bus.dl_set][bus.dl_word_select][{bus.dl_byte_select[1], 4'b0000} +: 16] <= bus.dl_word_to_store[15:0];
        default: dl_arr[bus.dl_set][bus.dl_word_select][{bus.dl_byte_select, 3'b000} +: 8] <= bus.dl_word_to_store[7:0];
      endcase
    end
  end

  // Traffic monitors.
  int          n_fills = 0, n_writes = 0, n_req_cycles = 0, n_unstable = 0;
  logic [31:0] fill_q[$];
  logic [31:0] last_w_addr = '0, last_w_data = '0;
  logic [1:0]  last_w_size = '0;
  logic [1:0]  last_dl_size = '0, last_dl_bs = '0;
  logic [2:0]  last_dl_word = '0;
  logic [31:0] last_dl_data = '0;
  logic        prev_req = 1'b0, prev_ready = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  always @(posedge clk) begin
    if (bus.mem_req === 1'b1) n_req_cycles <= n_req_cycles + 1;
    if (bus.mem_req === 1'b1 && bus.mem_ready === 1'b1) begin
      if (bus.mem_we === 1'b0) begin
        n_fills <= n_fills + 1;
        fill_q.push_back(bus.mem_addr);
      end else begin
        n_writes    <= n_writes + 1;
        last_w_addr <= bus.mem_addr;
        last_w_data <= bus.mem_wdata;
        last_w_size <= bus.mem_size;
      end
    end
    if (bus.dl_perform_write === 1'b1) begin
      last_dl_size <= bus.dl_op_size;
      last_dl_bs   <= bus.dl_byte_select;
      last_dl_word <= bus.dl_word_select;
      last_dl_data <= bus.dl_word_to_store;
    end
    if (rst_n === 1'b1 && prev_req && !prev_ready &&
        (bus.mem_req !== 1'b1 || bus.mem_addr !== prev_addr || bus.mem_wdata !== prev_wdata))
      n_unstable <= n_unstable + 1;
    prev_req   <= (bus.mem_req === 1'b1);
    prev_ready <= (bus.mem_ready === 1'b1);
    prev_addr  <= bus.mem_addr;
    prev_wdata <= bus.mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatch++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request once the controller is ready; return latency from transfer (-1 on timeout).
  task automatic do_req(input memory_operation_e op, input memory_operation_size_e size,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic with_flush,
                        output int lat, output logic [31:0] rdata, output logic err);
    lat = -1; rdata = '0; err = 1'b0;
    for (int c = 0; c < 20 && bus.req_ready !== 1'b1; c++) @(negedge clk);
    bus.req_op = op; bus.req_size = size; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_valid = 1'b1; bus.flush = with_flush;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin
        lat = c; rdata = bus.resp_rdata; err = bus.resp_error;
        break;
      end
    end
  endtask

  task automatic do_flush();
    for (int c = 0; c < 20 && bus.req_ready !== 1'b1; c++) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
  endtask

  int          lat, base_f, base_w, base_r, base_q;
  logic [31:0] rd;
  logic        er;

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = LOAD; bus.req_size = WORD;
    bus.req_addr = '0; bus.req_wdata = '0; bus.flush = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_dl_write", 32'(bus.dl_perform_write), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Cold load: full line fill, then replay hit.
    base_q = fill_q.size();
    do_req(LOAD, WORD, 32'h40, 32'h0, 1'b0, lat, rd, er);
    check("cold_latency", 32'(lat), 32'd10);
    check("cold_rdata", rd, 32'h100);
    check("cold_err", 32'(er), 32'd0);
    check("cold_fill_count", 32'(fill_q.size() - base_q), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("cold_fill_addr%0d", i), fill_q[base_q + i], 32'h40 + 32'(4 * i));

    // Load hit, no memory traffic.
    base_r = n_req_cycles;
    do_req(LOAD, WORD, 32'h44, 32'h0, 1'b0, lat, rd, er);
    check("hit_latency", 32'(lat), 32'd1);
    check("hit_rdata", rd, 32'h101);
    check("hit_no_mem", 32'(n_req_cycles - base_r), 32'd0);

    // Store byte hit: data-line write plus write-through.
    base_w = n_writes;
    do_req(STORE, BYTE, 32'h45, 32'hAB, 1'b0, lat, rd, er);
    check("store_latency", 32'(lat), 32'd2);
    check("store_rdata", rd, 32'h0);
    check("store_dl_bs", 32'(last_dl_bs), 32'd1);
    check("store_dl_size", 32'(last_dl_size), 32'(BYTE));
    check("store_dl_word", 32'(last_dl_word), 32'd1);
    check("store_dl_data", last_dl_data, 32'hAB);
    @(negedge clk);
    check("store_mem_writes", 32'(n_writes - base_w), 32'd1);
    check("store_mem_addr", last_w_addr, 32'h45);
    check("store_mem_size", 32'(last_w_size), 32'(BYTE));
    check("store_mem_data", last_w_data, 32'hAB);
    do_req(LOAD, WORD, 32'h44, 32'h0, 1'b0, lat, rd, er);
    check("after_store_rdata", rd, 32'h0000AB01);

    // Misaligned half: error, no memory, no state change.
    base_r = n_req_cycles;
    do_req(LOAD, HALF, 32'h43, 32'h0, 1'b0, lat, rd, er);
    check("misalign_latency", 32'(lat), 32'd1);
    check("misalign_err", 32'(er), 32'd1);
    check("misalign_rdata", rd, 32'h0);
    check("misalign_no_mem", 32'(n_req_cycles - base_r), 32'd0);
    do_req(LOAD, WORD, 32'h44, 32'h0, 1'b0, lat, rd, er);
    check("post_misalign_hit_lat", 32'(lat), 32'd1);

    // Flush together with a request: the request wins and still hits.
    do_req(LOAD, WORD, 32'h40, 32'h0, 1'b1, lat, rd, er);
    check("flush_req_lat", 32'(lat), 32'd1);
    check("flush_req_rdata", rd, 32'h100);

    // Conflict miss in set 2 with a stalling memory.
    stall_en = 1'b1;
    base_q = fill_q.size();
    do_req(LOAD, WORD, 32'h240, 32'h0, 1'b0, lat, rd, er);
    stall_en = 1'b0;
    check("conflict_done", 32'(lat > 10), 32'd1);
    check("conflict_rdata", rd, 32'h4100);
    check("conflict_fills", 32'(fill_q.size() - base_q), 32'd8);
    check("conflict_first_addr", fill_q[base_q], 32'h240);

    // Evicted line refills; then hit; flush; miss again.
    base_f = n_fills;
    do_req(LOAD, WORD, 32'h40, 32'h0, 1'b0, lat, rd, er);
    check("evicted_fills", 32'(n_fills - base_f), 32'd8);
    check("evicted_rdata", rd, 32'h100);
    do_req(LOAD, WORD, 32'h40, 32'h0, 1'b0, lat, rd, er);
    check("rehit_lat", 32'(lat), 32'd1);
    do_flush();
    base_f = n_fills;
    do_req(LOAD, WORD, 32'h40, 32'h0, 1'b0, lat, rd, er);
    check("post_flush_lat", 32'(lat), 32'd10);
    check("post_flush_fills", 32'(n_fills - base_f), 32'd8);

    // Reset in the middle of a fill.
    base_f = n_fills;
    for (int c = 0; c < 20 && bus.req_ready !== 1'b1; c++) @(negedge clk);
    bus.req_op = LOAD; bus.req_size = WORD; bus.req_addr = 32'h240; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int c = 0; c < 30 && (n_fills - base_f) < 3; c++) @(negedge clk);
    check("fills_before_reset", 32'(n_fills - base_f), 32'd3);
    rst_n = 1'b0;
    #1;
    check("midfill_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("midfill_rst_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    base_f = n_fills;
    do_req(LOAD, WORD, 32'h40, 32'h0, 1'b0, lat, rd, er);
    check("post_reset_fills", 32'(n_fills - base_f), 32'd8);
    check("post_reset_rdata", rd, 32'h100);
    check("post_reset_lat", 32'(lat), 32'd10);

    check("mem_stable_while_stalled", 32'(n_unstable), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
